ap_handshake_profiler: RTL and testbench
========================================

# ap_handshake_profiler

Synthesizable, parametrised ap_ctrl handshake profiler for HLS-generated designs: observes `N_CH` independent ap_start/ap_ready/ap_done/ap_continue channels, each tapped from the top kernel or a sub-function instance. Per channel it keeps saturating counters for:
- accepted and completed transactions;
- busy cycles and output-stall cycles;
- busy-interval length.

It supports pipelined (overlapping) transactions through an outstanding-transaction counter. Results are read through a registered read port, so statistics survive into hardware runs.

## Interface
- `N_CH`, 4, number of monitored channels (1..16).
- `CNT_W`, 32, width of every statistic counter (8..32).
- `MAX_OUT`, 4, maximum outstanding transactions per channel (1..15).
- `clock`  in  1  sole clock; all logic rising-edge.
- `reset`  in  1  asynchronous, active-low reset.
- `enable`  in  1  arms profiling (IDLE→RUN).
- `clear`  in  1  synchronous clear of all counters/flags, returns to IDLE.
- `finish`  in  1  freezes all counters (RUN→FROZEN).
- `ap_start`  in  N_CH  per-channel start.
- `ap_ready`  in  N_CH  per-channel ready.
- `ap_done`  in  N_CH  per-channel done.
- `ap_continue`  in  N_CH  per-channel continue (tie 1 for non-dataflow modules).
- `rd_en`  in  1  read request.
- `rd_ch`  in  4  channel index.
- `rd_addr`  in  3  register index.
- `rd_data`  out  CNT_W  read data.
- `rd_valid`  out  1  read data valid.
- `state`  out  2  global state: 0 IDLE, 1 RUN, 2 FROZEN.
- `err`  out  N_CH  sticky per-channel protocol error.

## Operation
- Global FSM: IDLE →(enable)→ RUN →(finish)→ FROZEN. `clear` from any state → IDLE. `clear` has priority over `finish`, and `finish` has priority over `enable`. Counters update only in RUN.
- Per channel, per RUN cycle:
  - accept = start&ready; complete = done&continue.
  - ACCEPT += accept; COMPLETE += complete.
  - outstanding += accept − complete. A simultaneous accept and complete leaves it unchanged.
  - BUSY += 1 when outstanding ≠ 0 (pre-update value) or accept.
  - STALL += 1 when done & ~continue.
  - Busy-interval counter runs while busy. On the cycle outstanding goes to 0, LAST_BUSY ← interval length including that cycle, then the interval counter resets.
- Zero-latency transaction (accept and complete in the same cycle, outstanding 0): BUSY += 1 and LAST_BUSY = 1.
- Protocol errors (sticky, cleared only by `clear`/reset):
  - complete with outstanding 0 and no accept → underflow; outstanding held at 0.
  - accept with outstanding = MAX_OUT and no complete → overflow; outstanding held.
- Saturation: every counter saturates at 2^CNT_W−1 and sets its channel's SAT flag.
- Register map, by `rd_addr`:
  - 0 ACCEPT
  - 1 COMPLETE
  - 2 BUSY
  - 3 STALL
  - 4 LAST_BUSY
  - 5 MAX_BUSY
  - 6 STATUS: bits[3:0] outstanding, [4] underflow, [5] overflow, [6] SAT
  - 7 reads 0
- `rd_ch` ≥ N_CH reads 0 with `rd_valid` still asserted.
- Reads are legal in any state and never disturb counters.

## Timing
- Reset values: all counters, outstanding, flags, `err`, `rd_data`, `rd_valid` = 0; `state` = IDLE.
- Read latency 1: `rd_en` at cycle t → `rd_data`/`rd_valid` at t+1; `rd_valid` is a one-cycle pulse per request. Back-to-back reads are supported at one per cycle.
- Read data reflects counter values registered before the cycle-t update.
- `enable` at t → state RUN at t+1; events at t+1 are counted.
- `finish` at t → events at t are still counted; state FROZEN at t+1.
- `clear` at t → all cleared at t+1; events at t are discarded.
- Reset deassertion mid-operation: counting resumes only after a new `enable`. Outstanding starts at 0, so in-flight completions flag underflow.

## Configuration
- `HS_PROF_MAXLAT_EN`:
  - Defined: MAX_BUSY holds the maximum LAST_BUSY value since clear, updated in the same cycle as LAST_BUSY.
  - Undefined: no MAX_BUSY logic is built and `rd_addr`=5 reads 0.

## Test plan
- Single channel, enable, start held 3 cycles with ready on the 3rd, done+continue 5 cycles later → ACCEPT=1, COMPLETE=1, LAST_BUSY=6, BUSY=6, STALL=0.
- Pipelined: accept on 3 consecutive cycles, completes 4 cycles after each → outstanding peaks at 3, ACCEPT=COMPLETE=3, LAST_BUSY=7, err=0.
- done high with continue low for 4 cycles, then continue → STALL=4, COMPLETE=1.
- done&continue with outstanding 0 → err[ch]=1, STATUS[4]=1, outstanding=0. MAX_OUT=2 and three accepts without completes → STATUS[5]=1, outstanding=2.
- CNT_W=8, 300 back-to-back accepts and completes → ACCEPT=255, STATUS[6]=1. Then finish, further events → counters unchanged, state=2. Then clear → all 0, state=0.
- With `HS_PROF_MAXLAT_EN`: busy intervals 5, 9, 3 → MAX_BUSY=9, LAST_BUSY=3. Without the macro → `rd_addr`=5 reads 0.

Source files
------------

// File: rtl/ap_handshake_profiler_if.sv
// rtl/ap_handshake_profiler_if.sv - ap_ctrl channel taps and registered read port bundle
interface ap_handshake_profiler_if #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 32
);
    logic [N_CH-1:0]  ap_start;
    logic [N_CH-1:0]  ap_ready;
    logic [N_CH-1:0]  ap_done;
    logic [N_CH-1:0]  ap_continue;
    logic             rd_en;
    logic [3:0]       rd_ch;
    logic [2:0]       rd_addr;
    logic [CNT_W-1:0] rd_data;
    logic             rd_valid;

    // Observed kernel / read master side
    modport master (
        output ap_start, ap_ready, ap_done, ap_continue, rd_en, rd_ch, rd_addr,
        input  rd_data, rd_valid
    );

    // Profiler side
    modport slave (
        input  ap_start, ap_ready, ap_done, ap_continue, rd_en, rd_ch, rd_addr,
        output rd_data, rd_valid
    );
endinterface

// File: rtl/ap_handshake_profiler.sv
// rtl/ap_handshake_profiler.sv - per-channel ap_ctrl handshake statistics; HS_PROF_MAXLAT_EN adds MAX_BUSY tracking
module ap_handshake_profiler #(
    parameter int N_CH    = 4,
    parameter int CNT_W   = 32,
    parameter int MAX_OUT = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 clear,
    input  logic                 finish,
    ap_handshake_profiler_if.slave bus,
    output logic [1:0]           state,
    output logic [N_CH-1:0]      err
);
    localparam logic [1:0]       ST_IDLE   = 2'd0;
    localparam logic [1:0]       ST_RUN    = 2'd1;
    localparam logic [1:0]       ST_FROZEN = 2'd2;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [3:0]       OUT_MAX   = 4'(MAX_OUT);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] accept_q    [N_CH];
    logic [CNT_W-1:0] accept_d    [N_CH];
    logic [CNT_W-1:0] complete_q  [N_CH];
    logic [CNT_W-1:0] complete_d  [N_CH];
    logic [CNT_W-1:0] busy_q      [N_CH];
    logic [CNT_W-1:0] busy_d      [N_CH];
    logic [CNT_W-1:0] stall_q     [N_CH];
    logic [CNT_W-1:0] stall_d     [N_CH];
    logic [CNT_W-1:0] last_busy_q [N_CH];
    logic [CNT_W-1:0] last_busy_d [N_CH];
    logic [CNT_W-1:0] interval_q  [N_CH];
    logic [CNT_W-1:0] interval_d  [N_CH];
`ifdef HS_PROF_MAXLAT_EN
    logic [CNT_W-1:0] max_busy_q  [N_CH];
    logic [CNT_W-1:0] max_busy_d  [N_CH];
`endif
    logic [3:0]       outst_q     [N_CH];
    logic [3:0]       outst_d     [N_CH];
    logic [N_CH-1:0]  underflow_q, underflow_d;
    logic [N_CH-1:0]  overflow_q, overflow_d;
    logic [N_CH-1:0]  sat_q, sat_d;
    logic [CNT_W-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;

    logic [N_CH-1:0]  acc, cmp, stl, busy_now;
    logic [CNT_W-1:0] interval_len [N_CH];

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        return (inc && (v != CNT_MAX)) ? v + CNT_ONE : v;
    endfunction

    // True when this increment leaves the counter pinned at its ceiling
    function automatic logic sat_hit(input logic [CNT_W-1:0] v, input logic inc);
        return inc && (v >= (CNT_MAX - CNT_ONE));
    endfunction

    assign acc = bus.ap_start & bus.ap_ready;
    assign cmp = bus.ap_done & bus.ap_continue;
    assign stl = bus.ap_done & ~bus.ap_continue;

    // Busy uses the pre-update outstanding count; interval_len includes the current cycle
    always_comb begin
        busy_now = '0;
        for (int c = 0; c < N_CH; c++) begin
            busy_now[c]     = (outst_q[c] != 4'd0) || acc[c];
            interval_len[c] = sat_inc(interval_q[c], 1'b1);
        end
    end

    // Global IDLE/RUN/FROZEN control; clear beats finish beats enable
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:   if (!finish && enable) state_d = ST_RUN;
                ST_RUN:    if (finish) state_d = ST_FROZEN;
                ST_FROZEN: state_d = ST_FROZEN;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // Per-channel statistics, advanced only while running
    always_comb begin
        accept_d    = accept_q;
        complete_d  = complete_q;
        busy_d      = busy_q;
        stall_d     = stall_q;
        last_busy_d = last_busy_q;
        interval_d  = interval_q;
`ifdef HS_PROF_MAXLAT_EN
        max_busy_d  = max_busy_q;
`endif
        outst_d     = outst_q;
        underflow_d = underflow_q;
        overflow_d  = overflow_q;
        sat_d       = sat_q;
        for (int c = 0; c < N_CH; c++) begin
            if (clear) begin
                accept_d[c]    = '0;
                complete_d[c]  = '0;
                busy_d[c]      = '0;
                stall_d[c]     = '0;
                last_busy_d[c] = '0;
                interval_d[c]  = '0;
`ifdef HS_PROF_MAXLAT_EN
                max_busy_d[c]  = '0;
`endif
                outst_d[c]     = 4'd0;
                underflow_d[c] = 1'b0;
                overflow_d[c]  = 1'b0;
                sat_d[c]       = 1'b0;
            end else if (state_q == ST_RUN) begin
                accept_d[c]   = sat_inc(accept_q[c], acc[c]);
                complete_d[c] = sat_inc(complete_q[c], cmp[c]);
                busy_d[c]     = sat_inc(busy_q[c], busy_now[c]);
                stall_d[c]    = sat_inc(stall_q[c], stl[c]);
                sat_d[c]      = sat_q[c] | sat_hit(accept_q[c], acc[c])
                              | sat_hit(complete_q[c], cmp[c]) | sat_hit(busy_q[c], busy_now[c])
                              | sat_hit(stall_q[c], stl[c]) | sat_hit(interval_q[c], busy_now[c]);
                if (acc[c] && !cmp[c]) begin
                    if (outst_q[c] == OUT_MAX) overflow_d[c] = 1'b1;
                    else                       outst_d[c] = outst_q[c] + 4'd1;
                end else if (!acc[c] && cmp[c]) begin
                    if (outst_q[c] == 4'd0) underflow_d[c] = 1'b1;
                    else                    outst_d[c] = outst_q[c] - 4'd1;
                end
                if (busy_now[c]) begin
                    if (outst_d[c] == 4'd0) begin
                        last_busy_d[c] = interval_len[c];
                        interval_d[c]  = '0;
`ifdef HS_PROF_MAXLAT_EN
                        if (interval_len[c] > max_busy_q[c]) max_busy_d[c] = interval_len[c];
`endif
                    end else begin
                        interval_d[c] = interval_len[c];
                    end
                end
            end
        end
    end

    // Read mux over registered values; unknown channels and address 7 return zero
    always_comb begin
        rd_valid_d = bus.rd_en;
        rd_data_d  = rd_data_q;
        if (bus.rd_en) begin
            rd_data_d = '0;
            for (int c = 0; c < N_CH; c++) begin
                if (int'(bus.rd_ch) == c) begin
                    case (bus.rd_addr)
                        3'd0: rd_data_d = accept_q[c];
                        3'd1: rd_data_d = complete_q[c];
                        3'd2: rd_data_d = busy_q[c];
                        3'd3: rd_data_d = stall_q[c];
                        3'd4: rd_data_d = last_busy_q[c];
`ifdef HS_PROF_MAXLAT_EN
                        3'd5: rd_data_d = max_busy_q[c];
`endif
                        3'd6: rd_data_d = {{(CNT_W-7){1'b0}}, sat_q[c], overflow_q[c],
                                           underflow_q[c], outst_q[c]};
                        default: rd_data_d = '0;
                    endcase
                end
            end
        end
    end

    // State registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            underflow_q <= '0;
            overflow_q  <= '0;
            sat_q       <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            for (int c = 0; c < N_CH; c++) begin
                accept_q[c]    <= '0;
                complete_q[c]  <= '0;
                busy_q[c]      <= '0;
                stall_q[c]     <= '0;
                last_busy_q[c] <= '0;
                interval_q[c]  <= '0;
`ifdef HS_PROF_MAXLAT_EN
                max_busy_q[c]  <= '0;
`endif
                outst_q[c]     <= 4'd0;
            end
        end else begin
            state_q     <= state_d;
            underflow_q <= underflow_d;
            overflow_q  <= overflow_d;
            sat_q       <= sat_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            for (int c = 0; c < N_CH; c++) begin
                accept_q[c]    <= accept_d[c];
                complete_q[c]  <= complete_d[c];
                busy_q[c]      <= busy_d[c];
                stall_q[c]     <= stall_d[c];
                last_busy_q[c] <= last_busy_d[c];
                interval_q[c]  <= interval_d[c];
`ifdef HS_PROF_MAXLAT_EN
                max_busy_q[c]  <= max_busy_d[c];
`endif
                outst_q[c]     <= outst_d[c];
            end
        end
    end

    assign state        = state_q;
    assign err          = underflow_q | overflow_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
endmodule

// File: tb/tb_ap_handshake_profiler.sv
// tb/tb_ap_handshake_profiler.sv - scoreboard bench for ap_handshake_profiler
module tb_ap_handshake_profiler;
    localparam int N_CH    = 4;
    localparam int CNT_W   = 8;
    localparam int MAX_OUT = 3;

    logic            clock  = 1'b0;
    logic            reset  = 1'b0;
    logic            enable = 1'b0;
    logic            clear  = 1'b0;
    logic            finish = 1'b0;
    logic [1:0]      state;
    logic [N_CH-1:0] err;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_q [$];
    string       tag_q [$];

    ap_handshake_profiler_if #(.N_CH(N_CH), .CNT_W(CNT_W)) bus ();

    ap_handshake_profiler #(.N_CH(N_CH), .CNT_W(CNT_W), .MAX_OUT(MAX_OUT)) dut (
        .clock  (clock),
        .reset  (reset),
        .enable (enable),
        .clear  (clear),
        .finish (finish),
        .bus    (bus.slave),
        .state  (state),
        .err    (err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Issue one read; the expectation waits in the scoreboard for rd_valid
    task automatic rd(input int ch, input int addr, input logic [31:0] exp, input string tag);
        bus.rd_en   = 1'b1;
        bus.rd_ch   = 4'(ch);
        bus.rd_addr = 3'(addr);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        step();
        bus.rd_en   = 1'b0;
    endtask

    // One transaction whose busy interval is len cycles (len >= 2)
    task automatic interval(input int ch, input int len);
        bus.ap_start[ch] = 1'b1;
        bus.ap_ready[ch] = 1'b1;
        step();
        bus.ap_start[ch] = 1'b0;
        bus.ap_ready[ch] = 1'b0;
        repeat (len - 2) step();
        bus.ap_done[ch] = 1'b1;
        step();
        bus.ap_done[ch] = 1'b0;
    endtask

    // Scoreboard consumer: every rd_valid pulse pops exactly one expectation
    always @(negedge clock) begin
        if (bus.rd_valid) begin
            if (exp_q.size() == 0) check("rd_spurious", 32'd1, 32'd0);
            else                   check(tag_q.pop_front(), 32'(bus.rd_data), exp_q.pop_front());
        end
    end

    initial begin
        bus.ap_start    = '0;
        bus.ap_ready    = '0;
        bus.ap_done     = '0;
        bus.ap_continue = '1;
        bus.rd_en       = 1'b0;
        bus.rd_ch       = 4'd0;
        bus.rd_addr     = 3'd0;

        repeat (3) step();
        check("rst_state", 32'(state), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        check("rst_rd_data", 32'(bus.rd_data), 32'd0);
        reset = 1'b1;
        step();
        rd(0, 0, 0, "rst_accept");
        rd(0, 6, 0, "rst_status");
        step();

        enable = 1'b1;
        step();
        enable = 1'b0;
        check("state_run", 32'(state), 32'd1);

        // Single transaction on ch0: start waits two cycles for ready, done 5 cycles later
        bus.ap_start[0] = 1'b1;
        step();
        step();
        bus.ap_ready[0] = 1'b1;
        step();
        bus.ap_start[0] = 1'b0;
        bus.ap_ready[0] = 1'b0;
        repeat (4) step();
        bus.ap_done[0] = 1'b1;
        step();
        bus.ap_done[0] = 1'b0;
        rd(0, 0, 1, "t1_accept");
        rd(0, 1, 1, "t1_complete");
        rd(0, 2, 6, "t1_busy");
        rd(0, 3, 0, "t1_stall");
        rd(0, 4, 6, "t1_last_busy");
        rd(0, 6, 0, "t1_status");
        step();

        // Pipelined on ch1: three back-to-back accepts, each completing 4 cycles later
        bus.ap_start[1] = 1'b1;
        bus.ap_ready[1] = 1'b1;
        repeat (3) step();
        bus.ap_start[1] = 1'b0;
        bus.ap_ready[1] = 1'b0;
        rd(1, 6, 3, "t2_outst_peak");
        bus.ap_done[1] = 1'b1;
        repeat (3) step();
        bus.ap_done[1] = 1'b0;
        rd(1, 0, 3, "t2_accept");
        rd(1, 1, 3, "t2_complete");
        rd(1, 4, 7, "t2_last_busy");
        rd(1, 2, 7, "t2_busy");
        step();
        check("t2_err", 32'(err), 32'd0);

        // Output stall on ch2: done held 4 cycles with continue low
        bus.ap_start[2] = 1'b1;
        bus.ap_ready[2] = 1'b1;
        step();
        bus.ap_start[2]    = 1'b0;
        bus.ap_ready[2]    = 1'b0;
        bus.ap_continue[2] = 1'b0;
        bus.ap_done[2]     = 1'b1;
        repeat (4) step();
        bus.ap_continue[2] = 1'b1;
        step();
        bus.ap_done[2] = 1'b0;
        rd(2, 3, 4, "t3_stall");
        rd(2, 1, 1, "t3_complete");
        rd(2, 4, 6, "t3_last_busy");
        step();
        check("t3_err", 32'(err), 32'd0);

        // Underflow then overflow on ch3
        bus.ap_done[3] = 1'b1;
        step();
        bus.ap_done[3] = 1'b0;
        step();
        check("t4_err_uf", 32'(err), 32'h8);
        rd(3, 6, 32'h10, "t4_status_uf");
        rd(3, 1, 1, "t4_complete_uf");
        bus.ap_start[3] = 1'b1;
        bus.ap_ready[3] = 1'b1;
        repeat (MAX_OUT + 1) step();
        bus.ap_start[3] = 1'b0;
        bus.ap_ready[3] = 1'b0;
        rd(3, 6, 32'h33, "t4_status_of");
        rd(3, 0, 4, "t4_accept_of");
        step();
        check("t4_err_of", 32'(err), 32'h8);

        // Busy intervals 5, 9, 3 on ch0
        interval(0, 5);
        step();
        interval(0, 9);
        step();
        interval(0, 3);
        step();
        rd(0, 4, 3, "t5_last_busy");
`ifdef HS_PROF_MAXLAT_EN
        rd(0, 5, 9, "t5_max_busy");
`else
        rd(0, 5, 0, "t5_max_busy_off");
`endif
        rd(0, 2, 23, "t5_busy");
        step();

        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clr1_state", 32'(state), 32'd0);
        check("clr1_err", 32'(err), 32'd0);
        rd(3, 6, 0, "clr1_status");
        rd(0, 2, 0, "clr1_busy");
        step();

        // Saturation with CNT_W=8, then finish and freeze
        enable = 1'b1;
        step();
        enable = 1'b0;
        bus.ap_start[0] = 1'b1;
        bus.ap_ready[0] = 1'b1;
        bus.ap_done[0]  = 1'b1;
        repeat (300) step();
        finish = 1'b1;
        bus.ap_start[1] = 1'b1;
        bus.ap_ready[1] = 1'b1;
        step();
        finish = 1'b0;
        repeat (3) step();
        bus.ap_start = '0;
        bus.ap_ready = '0;
        bus.ap_done  = '0;
        check("t6_state_frozen", 32'(state), 32'd2);
        rd(0, 0, 255, "t6_accept_sat");
        rd(0, 1, 255, "t6_complete_sat");
        rd(0, 2, 255, "t6_busy_sat");
        rd(0, 6, 32'h40, "t6_status_sat");
        rd(0, 4, 1, "t6_last_busy");
        rd(1, 0, 1, "t6_accept_frozen");
        rd(1, 6, 1, "t6_status_frozen");
        rd(5, 0, 0, "t6_bad_ch");
        rd(0, 7, 0, "t6_addr7");
        step();

        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clr2_state", 32'(state), 32'd0);
        rd(0, 0, 0, "clr2_accept");
        rd(0, 6, 0, "clr2_status");
        rd(1, 6, 0, "clr2_status1");
        step();

        // Reset while a transaction is in flight
        enable = 1'b1;
        step();
        enable = 1'b0;
        bus.ap_start[2] = 1'b1;
        bus.ap_ready[2] = 1'b1;
        step();
        bus.ap_start[2] = 1'b0;
        bus.ap_ready[2] = 1'b0;
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();
        check("t7_state_idle", 32'(state), 32'd0);
        enable = 1'b1;
        step();
        enable = 1'b0;
        bus.ap_done[2] = 1'b1;
        step();
        bus.ap_done[2] = 1'b0;
        step();
        check("t7_err", 32'(err), 32'h4);
        rd(2, 6, 32'h10, "t7_status");
        rd(2, 1, 1, "t7_complete");
        step();
        step();

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
